// File: rtl/data_mem_responder_if.sv
// Request/acknowledge bus between the core's data-memory port and the responder.
// The master drives the request fields; the slave returns completion status and read data.
interface data_mem_responder_if;
  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic        busy;

  modport master (output req, wen, addr, wdata, input ack, err, rdata, busy);
  modport slave  (input req, wen, addr, wdata, output ack, err, rdata, busy);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder with LATENCY wait states between request capture and ack.
// Out-of-window or misaligned accesses complete with err set and no array update.
module data_mem_responder #(
  parameter int unsigned WORD_DEPTH = 32,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(WORD_DEPTH);
  localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [0:WORD_DEPTH-1];

  logic             capture;
  logic             commit;
  logic             op_wen;
  logic [31:0]      op_addr, op_wdata, offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  // With LATENCY=0 the commit edge is also the capture edge, so decode the live bus in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    capture  = (state_q == IDLE) && bus.req;
    op_wen   = (state_q == IDLE) ? bus.wen   : wen_q;
    op_addr  = (state_q == IDLE) ? bus.addr  : addr_q;
    op_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
    offset   = op_addr - BASE;
    idx      = offset[IDX_W+1:2];
    in_range = (op_addr >= BASE) && ({2'b00, offset[31:2]} < DEPTH_W) && (offset[1:0] == 2'b00);

    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.req) begin
        if (LATENCY > 0) begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    commit = (state_d == RESP) && (state_q != RESP);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wen_q   <= bus.wen;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (commit) begin
        err_q <= !in_range;
        if (!in_range)    rdata_q <= 32'd0;
        else if (!op_wen) rdata_q <= mem[idx];
      end
    end
  end

  // NOTE: the array has no reset; contents survive rst and only a committed write changes them.
  always_ff @(posedge clk) begin
    if (!rst && commit && op_wen && in_range) mem[idx] <= op_wdata;
  end

  assign bus.ack   = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected ack cycle/err/rdata; monitors pop on each ack.
// dut0 runs with LATENCY=2, dut1 with LATENCY=0; both share BASE and clock/reset.
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   c0;
  exp_t q0[$];
  exp_t q1[$];

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();

  data_mem_responder #(.WORD_DEPTH(32), .LATENCY(2), .BASE(BASE)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  data_mem_responder #(.WORD_DEPTH(32), .LATENCY(0), .BASE(BASE)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  // cyc holds the number of the last rising edge; the cycle ending at edge k is cycle k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if0.ack) begin
      if (q0.size() == 0) check("dut0_unexpected_ack", 32'(if0.ack), 32'd0);
      else begin
        e = q0.pop_front();
        check("dut0_ack_cycle", 32'(cyc + 1), 32'(e.cyc));
        check("dut0_err", 32'(if0.err), 32'(e.err));
        check("dut0_rdata", if0.rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.ack) begin
      if (q1.size() == 0) check("dut1_unexpected_ack", 32'(if1.ack), 32'd0);
      else begin
        e = q1.pop_front();
        check("dut1_ack_cycle", 32'(cyc + 1), 32'(e.cyc));
        check("dut1_err", 32'(if1.err), 32'(e.err));
        check("dut1_rdata", if1.rdata, e.rdata);
      end
    end
  end

  task automatic wait_ack(input string name, input bit chk_busy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (chk_busy) check({name, "_busy"}, 32'(if0.busy), 32'd1);
      got = if0.ack;
    end
    check({name, "_ack_seen"}, 32'(got), 32'd1);
  endtask

  // One dut0 transaction; ack expected at capture edge + 1 + LATENCY (=2).
  task automatic txn(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd, input bit drop_early);
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(if0.busy), 32'd0);
    if0.req   = 1'b1;
    if0.wen   = w;
    if0.addr  = a;
    if0.wdata = d;
    q0.push_back('{cyc + 4, e_err, e_rd});
    if (drop_early) begin
      @(negedge clk);
      check({name, "_busy_early"}, 32'(if0.busy), 32'd1);
      if0.req   = 1'b0;
      if0.wen   = ~w;
      if0.addr  = 32'hFFFF_FFF0;
      if0.wdata = 32'hFFFF_FFFF;
    end
    wait_ack(name, 1'b1);
    if0.req = 1'b0;
    @(negedge clk);
    check({name, "_busy_after"}, 32'(if0.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    if0.req   = 1'b1;
    if0.wen   = 1'b1;
    if0.addr  = BASE;
    if0.wdata = 32'h5555_5555;
    if1.req   = 1'b1;
    if1.wen   = 1'b1;
    if1.addr  = BASE;
    if1.wdata = 32'h5555_5555;

    // Reset held two cycles with req high: outputs quiet, nothing captured.
    repeat (2) begin
      @(negedge clk);
      check("rst_ack", 32'(if0.ack), 32'd0);
      check("rst_err", 32'(if0.err), 32'd0);
      check("rst_busy", 32'(if0.busy), 32'd0);
      check("rst_rdata", if0.rdata, 32'd0);
      check("rst_busy_dut1", 32'(if1.busy), 32'd0);
    end
    rst     = 1'b0;
    if0.req = 1'b0;
    if1.req = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(if0.busy), 32'd0);
    check("post_rst_busy_dut1", 32'(if1.busy), 32'd0);

    txn("wr_w0", 1'b1, BASE, 32'hA5A5_0000, 1'b0, 32'd0, 1'b0);
    txn("wr_w2", 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0);
    check("mem2_after_write", dut0.mem[2], 32'hDEAD_BEEF);
    txn("rd_w2", 1'b0, BASE + 32'h8, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Error paths: idx 32, misaligned, below BASE.
    txn("wr_idx32", 1'b1, BASE + 32'h80, 32'h1234_5678, 1'b1, 32'd0, 1'b0);
    check("mem0_unchanged", dut0.mem[0], 32'hA5A5_0000);
    check("mem2_unchanged", dut0.mem[2], 32'hDEAD_BEEF);
    txn("rd_w2_again", 1'b0, BASE + 32'h8, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    txn("rd_misalign", 1'b0, BASE + 32'h2, 32'd0, 1'b1, 32'd0, 1'b0);
    txn("rd_below", 1'b0, 32'h0FFF_FFFC, 32'd0, 1'b1, 32'd0, 1'b0);

    // Last word of the window.
    txn("wr_w31", 1'b1, BASE + 32'h7C, 32'h7C7C_7C7C, 1'b0, 32'd0, 1'b0);
    txn("rd_w31", 1'b0, BASE + 32'h7C, 32'd0, 1'b0, 32'h7C7C_7C7C, 1'b0);

    // req dropped and fields scrambled one cycle after capture.
    txn("rd_drop", 1'b0, BASE + 32'h8, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // req held through ack: second capture at E0+4, second ack at E0+7.
    @(negedge clk);
    if0.req  = 1'b1;
    if0.wen  = 1'b0;
    if0.addr = BASE;
    c0       = cyc;
    q0.push_back('{c0 + 4, 1'b0, 32'hA5A5_0000});
    wait_ack("hold1", 1'b1);
    if0.addr = BASE + 32'h8;
    q0.push_back('{c0 + 8, 1'b0, 32'hDEAD_BEEF});
    wait_ack("hold2", 1'b0);
    if0.req = 1'b0;
    @(negedge clk);

    // Reset while WAITing: the write is abandoned and no ack appears.
    txn("wr_w1", 1'b1, BASE + 32'h4, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    if0.req   = 1'b1;
    if0.wen   = 1'b1;
    if0.addr  = BASE + 32'h4;
    if0.wdata = 32'h2222_2222;
    @(negedge clk);
    if0.req = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(if0.busy), 32'd0);
    check("midrst_rdata", if0.rdata, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("midrst_no_ack", 32'(if0.ack), 32'd0);
    end
    check("mem1_kept", dut0.mem[1], 32'h1111_1111);
    txn("rd_w1", 1'b0, BASE + 32'h4, 32'd0, 1'b0, 32'h1111_1111, 1'b0);

    // LATENCY=0: write at E0 (ack E0+1), read at E0+2 (ack E0+3), misaligned at E0+4 (ack E0+5).
    @(negedge clk);
    if1.req   = 1'b1;
    if1.wen   = 1'b1;
    if1.addr  = BASE + 32'hC;
    if1.wdata = 32'hCAFE_F00D;
    c0        = cyc;
    q1.push_back('{c0 + 2, 1'b0, 32'd0});
    @(negedge clk);
    if1.wen = 1'b0;
    q1.push_back('{c0 + 4, 1'b0, 32'hCAFE_F00D});
    repeat (2) @(negedge clk);
    if1.addr = BASE + 32'h1;
    q1.push_back('{c0 + 6, 1'b1, 32'd0});
    repeat (2) @(negedge clk);
    if1.req = 1'b0;
    repeat (3) @(negedge clk);
    check("dut1_mem3", dut1.mem[3], 32'hCAFE_F00D);

    check("dut0_pending", 32'(q0.size()), 32'd0);
    check("dut1_pending", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CHIP data-memory port with a request/acknowledge handshake and configurable wait states. It replaces the zero-wait combinational memory model behind the processor so the core's stall path can be exercised under realistic memory latency. It decodes a word-aligned address window starting at BASE and holds WORD_DEPTH words. Accesses outside that window, or misaligned accesses, complete with an error flag.

## Interface
- WORD_DEPTH, 32: number of 32-bit words stored.
- LATENCY, 2: wait cycles inserted between request capture and acknowledge; legal range 0..15.
- BASE, 32'h0000_0000: byte address of word 0; must be word-aligned.
- clk  input  1  the only clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  the initiator requests a transaction; sampled only in IDLE.
- wen  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  write data; sampled with req.
- ack  output  1  one-cycle pulse marking transaction completion.
- err  output  1  valid with ack; 1 = address out of range or misaligned.
- rdata  output  32  read data; valid in the ack cycle and held until the next ack.
- busy  output  1  high from the cycle after capture through the ack cycle.

## Operation
- FSM has three states:
  - IDLE: when req=1, latch wen/addr/wdata. Go to WAIT if LATENCY>0, else go to RESP.
  - WAIT: load counter with LATENCY-1 on entry and decrement each cycle. Go to RESP when the counter is 0.
  - RESP: ack=1 for this single cycle, then go to IDLE unconditionally.
- Decode uses the latched addr:
  - idx = (addr - BASE) >> 2.
  - In range when addr >= BASE, idx < WORD_DEPTH and addr[1:0] == 0.
  - Subtraction is unsigned 32-bit. An addr below BASE is out of range and must not wrap to a valid idx.
- Write in range: mem[idx] <= wdata on the edge entering RESP. rdata is unchanged; err=0.
- Read in range: rdata <= mem[idx] on the edge entering RESP; err=0.
- Out of range or misaligned: err=1 with ack. No array write. rdata <= 0.
- The array is named mem, indexed 0..WORD_DEPTH-1, and is hierarchically accessible so benches can preload it and read it back. Reset does not clear the array.
- Once captured, a transaction always completes. Dropping req, or changing wen/addr/wdata, during WAIT/RESP has no effect.
- Requests presented while not in IDLE are ignored; the initiator must keep req high until ack.

## Timing
- Reset values: ack=0, err=0, rdata=0, busy=0, state=IDLE, counter=0.
- Request sampled at edge E0 gives ack high in cycle E0+1+LATENCY, i.e. exactly LATENCY+1 cycles after capture.
- A req held high through the ack cycle is not captured in that cycle. It is captured at the first IDLE edge after it. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Read-after-write to the same word returns the new data, since the write commits before the next capture.
- busy falls in the cycle after ack; ack and busy are both high in the RESP cycle.
- rst=1 in any state takes effect at the next edge:
  - return to IDLE with no array write;
  - the pending ack is never issued;
  - all outputs return to their reset values;
  - rst overrides a simultaneous req.
- err and rdata are registered and change only on the edge entering RESP, or on reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=1 -> ack, err, busy and rdata all 0, and no capture occurs.
- Use LATENCY=2, BASE=32'h1000_0000.
  - Write 32'hDEADBEEF to 32'h1000_0008 at E0 -> busy high E0+1..E0+3, ack at E0+3 with err=0, mem[2]=32'hDEADBEEF.
  - Then read 32'h1000_0008 -> rdata=32'hDEADBEEF in its ack cycle.
- Error paths:
  - Write to 32'h1000_0080 (idx 32) -> ack with err=1, mem unchanged, rdata=0.
  - Read 32'h1000_0002 -> err=1.
  - Read 32'h0FFF_FFFC -> err=1.
- Handshake:
  - Drop req one cycle after capture -> ack still at E0+3.
  - Hold req through ack -> the second capture is at E0+4 and the second ack is at E0+7.
- Reset mid-WAIT: a write to 32'h1000_0004 with rst=1 at E0+1 -> no ack is ever issued and mem[1] keeps its prior value.
- LATENCY=0: a read captured at E0 -> ack at E0+1, then the next capture at E0+2 gives an ack at E0+3.
